// File: rtl/ctrl_unit_mc_if.sv
`default_nettype none
// ctrl_unit_mc_if: control unit <-> datapath bundle (IR fields, flags, enables, selects).
// Rev 1.0
interface ctrl_unit_mc_if;
   logic [5:0] OPCODE;
   logic [5:0] FUNCT;
   logic       overflow;
   logic       zero;
   logic       multStop;
   logic       divStop;
   logic       divZero;
   logic       MEM_read;
   logic       MEM_write;
   logic       PC_write;
   logic       IR_write;
   logic       REG_write;
   logic       AB_write;
   logic       ALUOUT_write;
   logic       EPC_write;
   logic       HILO_write;
   logic       MULT_control;
   logic       DIV_control;
   logic [2:0] ALU_control;
   logic [1:0] ALUSRCA_select;
   logic [1:0] ALUSRCB_select;
   logic [2:0] PCSOURCE_select;
   logic [2:0] IORD_select;
   logic [2:0] REGDST_select;
   logic [3:0] MEMTOREG_select;
   logic [1:0] EXC_cause;

   modport master (
      input  OPCODE, FUNCT, overflow, zero, multStop, divStop, divZero,
      output MEM_read, MEM_write, PC_write, IR_write, REG_write, AB_write,
             ALUOUT_write, EPC_write, HILO_write, MULT_control, DIV_control,
             ALU_control, ALUSRCA_select, ALUSRCB_select, PCSOURCE_select,
             IORD_select, REGDST_select, MEMTOREG_select, EXC_cause
   );

   modport slave (
      output OPCODE, FUNCT, overflow, zero, multStop, divStop, divZero,
      input  MEM_read, MEM_write, PC_write, IR_write, REG_write, AB_write,
             ALUOUT_write, EPC_write, HILO_write, MULT_control, DIV_control,
             ALU_control, ALUSRCA_select, ALUSRCB_select, PCSOURCE_select,
             IORD_select, REGDST_select, MEMTOREG_select, EXC_cause
   );
endinterface
`default_nettype wire

// File: rtl/ctrl_unit_mc.sv
`default_nettype none
// ctrl_unit_mc: multicycle MIPS-subset main control FSM with memory latency, mult/div and traps.
// Rev 1.0
module ctrl_unit_mc #(
   parameter int unsigned MEM_LAT = 2,
   parameter bit          EXC_EN  = 1'b1
) (
   input  wire logic      clk,
   input  wire logic      reset,
   ctrl_unit_mc_if.master bus
);
   localparam logic [3:0] LAT      = 4'(MEM_LAT);
   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09, OP_LW   = 6'h23, OP_SW   = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08, FN_MFHI = 6'h10, FN_MFLO = 6'h12;
   localparam logic [5:0] FN_RTE   = 6'h13, FN_MULT = 6'h18, FN_DIV  = 6'h1A;
   localparam logic [5:0] FN_ADD   = 6'h20, FN_SUB  = 6'h22, FN_AND  = 6'h24;

   typedef enum logic [4:0] {
      S_RST, S_FETCH, S_FWAIT, S_IR_LOAD, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I,
      S_WB_I, S_BR_CMP, S_BR_TAKE, S_ADDR, S_ST, S_LD, S_LD_WAIT, S_WB_LD,
      S_JMP, S_JAL_LINK, S_JR, S_RTE, S_MD_START, S_MD_WAIT, S_MD_DONE, S_WB_MF,
      S_EXC, S_EXC_RD, S_EXC_WAIT, S_EXC_JMP
   } state_t;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       pc_write;
      logic       ir_write;
      logic       reg_write;
      logic       ab_write;
      logic       aluout_write;
      logic       epc_write;
      logic       hilo_write;
      logic       mult_control;
      logic       div_control;
      logic [2:0] alu_control;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [2:0] pcsource;
      logic [2:0] iord;
      logic [2:0] regdst;
      logic [3:0] memtoreg;
      logic [1:0] exc_cause;
   } ctrl_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [1:0] cause_q, cause_d;
   ctrl_t      out_q, out_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      case (state_q)
         S_RST:      state_d = S_FETCH;
         S_FETCH: begin
            cnt_d   = LAT;
            state_d = (MEM_LAT == 0) ? S_IR_LOAD : S_FWAIT;
         end
         S_FWAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_d = S_IR_LOAD;
         end
         S_IR_LOAD:  state_d = S_DECODE;
         S_DECODE: begin
            // Unknown encodings trap when enabled, otherwise fall through as a NOP.
            state_d = EXC_EN ? S_EXC : S_FETCH;
            if (EXC_EN) cause_d = 2'd1;
            case (OPCODE_w())
               OP_RTYPE: begin
                  case (bus.FUNCT)
                     FN_ADD, FN_SUB, FN_AND: state_d = S_EXEC_R;
                     FN_MULT:                state_d = S_MD_START;
                     FN_DIV: begin
                        if (bus.divZero && EXC_EN) cause_d = 2'd3;
                        else                        state_d = S_MD_START;
                     end
                     FN_MFHI, FN_MFLO:       state_d = S_WB_MF;
                     FN_JR:                  state_d = S_JR;
                     FN_RTE:                 state_d = S_RTE;
                     default: ;
                  endcase
               end
               OP_ADDI, OP_ADDIU:            state_d = S_EXEC_I;
               OP_BEQ, OP_BNE:               state_d = S_BR_CMP;
               OP_LW, OP_SW:                 state_d = S_ADDR;
               OP_J:                         state_d = S_JMP;
               OP_JAL:                       state_d = S_JAL_LINK;
               default: ;
            endcase
            if (state_d != S_EXC) cause_d = cause_q;
         end
         S_EXEC_R: begin
            state_d = S_WB_R;
            if (bus.overflow && EXC_EN && (bus.FUNCT != FN_AND)) begin
               state_d = S_EXC;
               cause_d = 2'd2;
            end
         end
         S_EXEC_I: begin
            state_d = S_WB_I;
            if (bus.overflow && EXC_EN && (bus.OPCODE == OP_ADDI)) begin
               state_d = S_EXC;
               cause_d = 2'd2;
            end
         end
         S_BR_CMP: begin
            if ((bus.OPCODE == OP_BEQ) ? bus.zero : !bus.zero) state_d = S_BR_TAKE;
            else                                                state_d = S_FETCH;
         end
         S_ADDR:     state_d = (bus.OPCODE == OP_SW) ? S_ST : S_LD;
         S_LD: begin
            cnt_d   = LAT;
            state_d = (MEM_LAT == 0) ? S_WB_LD : S_LD_WAIT;
         end
         S_LD_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_d = S_WB_LD;
         end
         S_JAL_LINK: state_d = S_JMP;
         S_MD_START: state_d = S_MD_WAIT;
         S_MD_WAIT: begin
            if ((bus.FUNCT == FN_DIV) ? bus.divStop : bus.multStop) state_d = S_MD_DONE;
         end
         S_EXC:      state_d = S_EXC_RD;
         S_EXC_RD: begin
            cnt_d   = LAT;
            state_d = (MEM_LAT == 0) ? S_EXC_JMP : S_EXC_WAIT;
         end
         S_EXC_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_d = S_EXC_JMP;
         end
         default:    state_d = S_FETCH;
      endcase
      if (state_d == S_FETCH) cause_d = 2'd0;

      // Outputs are decoded from the next state so the registered copy lines up with it.
      out_d           = '0;
      out_d.exc_cause = cause_d;
      case (state_d)
         S_FETCH, S_FWAIT: out_d.mem_read = 1'b1;
         S_IR_LOAD: begin
            out_d.ir_write    = 1'b1;
            out_d.pc_write    = 1'b1;
            out_d.alusrcb     = 2'd1;
            out_d.alu_control = 3'd1;
         end
         S_DECODE: begin
            out_d.ab_write     = 1'b1;
            out_d.aluout_write = 1'b1;
            out_d.alusrcb      = 2'd3;
            out_d.alu_control  = 3'd1;
         end
         S_EXEC_R: begin
            out_d.alusrca      = 2'd1;
            out_d.aluout_write = 1'b1;
            out_d.alu_control  = (bus.FUNCT == FN_SUB) ? 3'd2 :
                                 (bus.FUNCT == FN_AND) ? 3'd3 : 3'd1;
         end
         S_WB_R: begin
            out_d.reg_write = 1'b1;
            out_d.regdst    = 3'd1;
         end
         S_EXEC_I: begin
            out_d.alusrca      = 2'd1;
            out_d.alusrcb      = 2'd2;
            out_d.alu_control  = 3'd1;
            out_d.aluout_write = 1'b1;
         end
         S_WB_I:     out_d.reg_write = 1'b1;
         S_BR_CMP: begin
            out_d.alusrca     = 2'd1;
            out_d.alu_control = 3'd2;
         end
         S_BR_TAKE: begin
            out_d.pc_write = 1'b1;
            out_d.pcsource = 3'd1;
         end
         S_ADDR: begin
            out_d.alusrca      = 2'd1;
            out_d.alusrcb      = 2'd2;
            out_d.alu_control  = 3'd1;
            out_d.aluout_write = 1'b1;
         end
         S_ST: begin
            out_d.mem_write = 1'b1;
            out_d.iord      = 3'd1;
         end
         S_LD, S_LD_WAIT: begin
            out_d.mem_read = 1'b1;
            out_d.iord     = 3'd1;
         end
         S_WB_LD: begin
            out_d.reg_write = 1'b1;
            out_d.memtoreg  = 4'd1;
         end
         S_JMP: begin
            out_d.pc_write = 1'b1;
            out_d.pcsource = 3'd2;
         end
         S_JAL_LINK: begin
            out_d.reg_write = 1'b1;
            out_d.regdst    = 3'd2;
            out_d.memtoreg  = 4'd4;
         end
         S_JR: begin
            out_d.pc_write = 1'b1;
            out_d.pcsource = 3'd5;
         end
         S_RTE: begin
            out_d.pc_write = 1'b1;
            out_d.pcsource = 3'd3;
         end
         S_MD_START: begin
            out_d.div_control  = (bus.FUNCT == FN_DIV);
            out_d.mult_control = (bus.FUNCT != FN_DIV);
         end
         S_MD_DONE:  out_d.hilo_write = 1'b1;
         S_WB_MF: begin
            out_d.reg_write = 1'b1;
            out_d.regdst    = 3'd1;
            out_d.memtoreg  = (bus.FUNCT == FN_MFLO) ? 4'd3 : 4'd2;
         end
         S_EXC: begin
            out_d.alusrcb     = 2'd1;
            out_d.alu_control = 3'd2;
            out_d.epc_write   = 1'b1;
         end
         S_EXC_RD, S_EXC_WAIT: begin
            out_d.mem_read = 1'b1;
            out_d.iord     = 3'({1'b0, cause_d}) + 3'd1;
         end
         S_EXC_JMP: begin
            out_d.pc_write = 1'b1;
            out_d.pcsource = 3'd4;
         end
         default: ;
      endcase
   end

   function automatic logic [5:0] OPCODE_w();
      return bus.OPCODE;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_RST;
         cnt_q   <= 4'd0;
         cause_q <= 2'd0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
         out_q   <= out_d;
      end
   end

   assign bus.MEM_read        = out_q.mem_read;
   assign bus.MEM_write       = out_q.mem_write;
   assign bus.PC_write        = out_q.pc_write;
   assign bus.IR_write        = out_q.ir_write;
   assign bus.REG_write       = out_q.reg_write;
   assign bus.AB_write        = out_q.ab_write;
   assign bus.ALUOUT_write    = out_q.aluout_write;
   assign bus.EPC_write       = out_q.epc_write;
   assign bus.HILO_write      = out_q.hilo_write;
   assign bus.MULT_control    = out_q.mult_control;
   assign bus.DIV_control     = out_q.div_control;
   assign bus.ALU_control     = out_q.alu_control;
   assign bus.ALUSRCA_select  = out_q.alusrca;
   assign bus.ALUSRCB_select  = out_q.alusrcb;
   assign bus.PCSOURCE_select = out_q.pcsource;
   assign bus.IORD_select     = out_q.iord;
   assign bus.REGDST_select   = out_q.regdst;
   assign bus.MEMTOREG_select = out_q.memtoreg;
   assign bus.EXC_cause       = out_q.exc_cause;
endmodule
`default_nettype wire

// File: tb/tb_ctrl_unit_mc.sv
`default_nettype none
// tb_ctrl_unit_mc: directed scoreboard bench over three parameter variants of ctrl_unit_mc.
module tb_ctrl_unit_mc;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0, rst1, rst2;
   logic [5:0] opcode, funct;
   logic       ovf, zro, mstop, dstop, dzero;

   ctrl_unit_mc_if if0 ();
   ctrl_unit_mc_if if1 ();
   ctrl_unit_mc_if if2 ();

   ctrl_unit_mc #(.MEM_LAT(2), .EXC_EN(1'b1)) u0 (.clk(clk), .reset(rst0), .bus(if0.master));
   ctrl_unit_mc #(.MEM_LAT(0), .EXC_EN(1'b1)) u1 (.clk(clk), .reset(rst1), .bus(if1.master));
   ctrl_unit_mc #(.MEM_LAT(2), .EXC_EN(1'b0)) u2 (.clk(clk), .reset(rst2), .bus(if2.master));

   assign {if0.OPCODE, if0.FUNCT, if0.overflow, if0.zero, if0.multStop, if0.divStop, if0.divZero} =
          {opcode, funct, ovf, zro, mstop, dstop, dzero};
   assign {if1.OPCODE, if1.FUNCT, if1.overflow, if1.zero, if1.multStop, if1.divStop, if1.divZero} =
          {opcode, funct, ovf, zro, mstop, dstop, dzero};
   assign {if2.OPCODE, if2.FUNCT, if2.overflow, if2.zero, if2.multStop, if2.divStop, if2.divZero} =
          {opcode, funct, ovf, zro, mstop, dstop, dzero};

   logic [32:0] obs0, obs1, obs2;
   assign obs0 = {if0.MEM_read, if0.MEM_write, if0.PC_write, if0.IR_write, if0.REG_write, if0.AB_write,
                  if0.ALUOUT_write, if0.EPC_write, if0.HILO_write, if0.MULT_control, if0.DIV_control,
                  if0.ALU_control, if0.ALUSRCA_select, if0.ALUSRCB_select, if0.PCSOURCE_select,
                  if0.IORD_select, if0.REGDST_select, if0.MEMTOREG_select, if0.EXC_cause};
   assign obs1 = {if1.MEM_read, if1.MEM_write, if1.PC_write, if1.IR_write, if1.REG_write, if1.AB_write,
                  if1.ALUOUT_write, if1.EPC_write, if1.HILO_write, if1.MULT_control, if1.DIV_control,
                  if1.ALU_control, if1.ALUSRCA_select, if1.ALUSRCB_select, if1.PCSOURCE_select,
                  if1.IORD_select, if1.REGDST_select, if1.MEMTOREG_select, if1.EXC_cause};
   assign obs2 = {if2.MEM_read, if2.MEM_write, if2.PC_write, if2.IR_write, if2.REG_write, if2.AB_write,
                  if2.ALUOUT_write, if2.EPC_write, if2.HILO_write, if2.MULT_control, if2.DIV_control,
                  if2.ALU_control, if2.ALUSRCA_select, if2.ALUSRCB_select, if2.PCSOURCE_select,
                  if2.IORD_select, if2.REGDST_select, if2.MEMTOREG_select, if2.EXC_cause};

   // Bit positions of each field inside the packed observation vector.
   localparam int CAUSE = 0,  M2R  = 2,  RDST  = 6,  IORD = 9,  PCSRC = 12, ALUB = 15;
   localparam int ALUA  = 17, ALUC = 19, DIVC  = 22, MULC = 23, HILO  = 24, EPCW = 25;
   localparam int AOUTW = 26, ABW  = 27, REGW  = 28, IRW  = 29, PCW   = 30, MEMW = 31, MEMRD = 32;

   typedef struct {
      string       tag;
      int          cyc;
      int          lsb;
      int          wid;
      logic [63:0] val;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   divpulses;

   function automatic logic [32:0] obs(input int d);
      case (d)
         0:       return obs0;
         1:       return obs1;
         default: return obs2;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic expect_at(input string tag, input int cyc, input int lsb, input int wid,
                            input logic [63:0] val);
      exp_t e;
      e.tag = tag; e.cyc = cyc; e.lsb = lsb; e.wid = wid; e.val = val;
      sb.push_back(e);
   endtask

   task automatic start(input int d, input logic [5:0] op, input logic [5:0] fn,
                        input logic ov, input logic z, input logic dz);
      opcode = op; funct = fn; ovf = ov; zro = z; dzero = dz; mstop = 1'b0; dstop = 1'b0;
      rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check($sformatf("reset_state_dut%0d", d), 64'(obs(d)), 64'd0);
      case (d)
         0:       rst0 = 1'b1;
         1:       rst1 = 1'b1;
         default: rst2 = 1'b1;
      endcase
   endtask

   // Cycle c is the state entered on the c-th rising edge after reset release.
   task automatic run(input int d, input int ncyc, input int stop_a, input int stop_b);
      logic [32:0] o;
      logic [63:0] got;
      divpulses = 0;
      for (int c = 1; c <= ncyc; c++) begin
         @(posedge clk);
         @(negedge clk);
         o = obs(d);
         if (o[DIVC]) divpulses++;
         while (sb.size() > 0 && sb[0].cyc == c) begin
            exp_t e = sb.pop_front();
            got = (64'(o) >> e.lsb) & ((64'd1 << e.wid) - 64'd1);
            check(e.tag, got, e.val);
         end
         dstop = (c == stop_a) || (c == stop_b);
      end
      dstop = 1'b0;
      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL unreached_expectations observed=%0d expected=0", sb.size());
      end
      sb.delete();
   endtask

   initial begin
      rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
      opcode = '0; funct = '0; ovf = 1'b0; zro = 1'b0; mstop = 1'b0; dstop = 1'b0; dzero = 1'b0;

      // mult, then asynchronous reset while waiting for multStop
      start(0, 6'h00, 6'h18, 1'b0, 1'b0, 1'b0);
      expect_at("fetch_after_release", 1, MEMRD, 1, 1);
      expect_at("mult_start_pulse", 6, MULC, 1, 1);
      expect_at("mult_pulse_single", 7, MULC, 1, 0);
      run(0, 10, 0, 0);
      #2 rst0 = 1'b0;
      #1 check("async_reset_all_zero", 64'(obs0), 64'd0);
      @(negedge clk);
      rst0 = 1'b1;
      expect_at("rerelease_fetch_memrd", 1, MEMRD, 1, 1);
      expect_at("rerelease_fetch_iord", 1, IORD, 3, 0);
      run(0, 1, 0, 0);

      // add, MEM_LAT=2
      start(0, 6'h00, 6'h20, 1'b0, 1'b0, 1'b0);
      expect_at("add_fwait_memrd", 3, MEMRD, 1, 1);
      expect_at("add_fwait_no_irw", 3, IRW, 1, 0);
      expect_at("add_irload_irw", 4, IRW, 1, 1);
      expect_at("add_irload_pcw", 4, PCW, 1, 1);
      expect_at("add_irload_alub", 4, ALUB, 2, 1);
      expect_at("add_decode_abw", 5, ABW, 1, 1);
      expect_at("add_decode_alub", 5, ALUB, 2, 3);
      expect_at("add_exec_aluc", 6, ALUC, 3, 1);
      expect_at("add_exec_alua", 6, ALUA, 2, 1);
      expect_at("add_exec_aoutw", 6, AOUTW, 1, 1);
      expect_at("add_wb_regw", 7, REGW, 1, 1);
      expect_at("add_wb_regdst", 7, RDST, 3, 1);
      expect_at("add_next_fetch", 8, MEMRD, 1, 1);
      expect_at("add_fetch_no_regw", 8, REGW, 1, 0);
      run(0, 8, 0, 0);

      // add, MEM_LAT=0
      start(1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b0);
      expect_at("lat0_irload", 2, IRW, 1, 1);
      expect_at("lat0_wb_regw", 5, REGW, 1, 1);
      expect_at("lat0_wb_regdst", 5, RDST, 3, 1);
      expect_at("lat0_next_fetch", 6, MEMRD, 1, 1);
      run(1, 6, 0, 0);

      // addi with overflow traps
      start(0, 6'h08, 6'h00, 1'b1, 1'b0, 1'b0);
      expect_at("addi_exec_alub", 6, ALUB, 2, 2);
      expect_at("addi_exc_epcw", 7, EPCW, 1, 1);
      expect_at("addi_exc_no_regw", 7, REGW, 1, 0);
      expect_at("addi_exc_aluc", 7, ALUC, 3, 2);
      expect_at("addi_exc_cause", 7, CAUSE, 2, 2);
      expect_at("addi_excrd_memrd", 8, MEMRD, 1, 1);
      expect_at("addi_excrd_iord", 8, IORD, 3, 3);
      expect_at("addi_excwait_iord", 10, IORD, 3, 3);
      expect_at("addi_excjmp_pcw", 11, PCW, 1, 1);
      expect_at("addi_excjmp_pcsrc", 11, PCSRC, 3, 4);
      expect_at("addi_cause_held", 11, CAUSE, 2, 2);
      expect_at("addi_fetch_cause_clr", 12, CAUSE, 2, 0);
      expect_at("addi_fetch_memrd", 12, MEMRD, 1, 1);
      run(0, 12, 0, 0);

      // addiu with overflow writes back normally
      start(0, 6'h09, 6'h00, 1'b1, 1'b0, 1'b0);
      expect_at("addiu_wb_regw", 7, REGW, 1, 1);
      expect_at("addiu_wb_regdst", 7, RDST, 3, 0);
      expect_at("addiu_no_epcw", 7, EPCW, 1, 0);
      expect_at("addiu_fetch", 8, MEMRD, 1, 1);
      run(0, 8, 0, 0);

      // beq taken / bne not taken
      start(0, 6'h04, 6'h00, 1'b0, 1'b1, 1'b0);
      expect_at("beq_cmp_aluc", 6, ALUC, 3, 2);
      expect_at("beq_take_pcw", 7, PCW, 1, 1);
      expect_at("beq_take_pcsrc", 7, PCSRC, 3, 1);
      expect_at("beq_fetch", 8, MEMRD, 1, 1);
      run(0, 8, 0, 0);
      start(0, 6'h05, 6'h00, 1'b0, 1'b1, 1'b0);
      expect_at("bne_fetch", 7, MEMRD, 1, 1);
      expect_at("bne_no_pcw", 7, PCW, 1, 0);
      run(0, 7, 0, 0);

      // lw with two wait cycles
      start(0, 6'h23, 6'h00, 1'b0, 1'b0, 1'b0);
      expect_at("lw_ld_memrd", 7, MEMRD, 1, 1);
      expect_at("lw_ld_iord", 7, IORD, 3, 1);
      expect_at("lw_wait_iord", 9, IORD, 3, 1);
      expect_at("lw_wb_regw", 10, REGW, 1, 1);
      expect_at("lw_wb_m2r", 10, M2R, 4, 1);
      expect_at("lw_fetch_iord", 11, IORD, 3, 0);
      run(0, 11, 0, 0);

      // jal
      start(0, 6'h03, 6'h00, 1'b0, 1'b0, 1'b0);
      expect_at("jal_link_regdst", 6, RDST, 3, 2);
      expect_at("jal_link_m2r", 6, M2R, 4, 4);
      expect_at("jal_jmp_pcsrc", 7, PCSRC, 3, 2);
      expect_at("jal_jmp_pcw", 7, PCW, 1, 1);
      run(0, 7, 0, 0);

      // div: early stop ignored, real stop 33 cycles after the start pulse
      start(0, 6'h00, 6'h1A, 1'b0, 1'b0, 1'b0);
      expect_at("div_start_pulse", 6, DIVC, 1, 1);
      expect_at("div_early_stop_ignored", 8, HILO, 1, 0);
      expect_at("div_wait_no_hilo", 39, HILO, 1, 0);
      expect_at("div_done_hilo", 40, HILO, 1, 1);
      expect_at("div_fetch", 41, MEMRD, 1, 1);
      run(0, 41, 6, 39);
      check("div_pulse_count", 64'(divpulses), 64'd1);

      // div by zero traps without a start pulse
      start(0, 6'h00, 6'h1A, 1'b0, 1'b0, 1'b1);
      expect_at("div0_exc_epcw", 6, EPCW, 1, 1);
      expect_at("div0_exc_cause", 6, CAUSE, 2, 3);
      expect_at("div0_excrd_iord", 7, IORD, 3, 4);
      expect_at("div0_excjmp_pcsrc", 10, PCSRC, 3, 4);
      expect_at("div0_fetch", 11, MEMRD, 1, 1);
      run(0, 11, 0, 0);
      check("div0_no_pulse", 64'(divpulses), 64'd0);

      // invalid opcode, traps enabled and disabled
      start(0, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b0);
      expect_at("inv_exc_cause", 6, CAUSE, 2, 1);
      expect_at("inv_exc_epcw", 6, EPCW, 1, 1);
      expect_at("inv_excrd_iord", 7, IORD, 3, 2);
      expect_at("inv_excrd_memrd", 7, MEMRD, 1, 1);
      run(0, 7, 0, 0);
      start(2, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b0);
      expect_at("noexc_inv_fetch", 6, MEMRD, 1, 1);
      expect_at("noexc_inv_no_epcw", 6, EPCW, 1, 0);
      expect_at("noexc_inv_no_pcw", 6, PCW, 1, 0);
      expect_at("noexc_inv_no_regw", 6, REGW, 1, 0);
      expect_at("noexc_inv_cause", 6, CAUSE, 2, 0);
      run(2, 6, 0, 0);

      // overflow ignored when traps are disabled
      start(2, 6'h00, 6'h20, 1'b1, 1'b0, 1'b0);
      expect_at("noexc_ovf_regw", 7, REGW, 1, 1);
      expect_at("noexc_ovf_no_epcw", 7, EPCW, 1, 0);
      run(2, 7, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
